regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//   Owns the single register-file write port of the RISC-V core. Merges the in-order pipeline
//   writeback (reg_wr/reg_wr_data from writeback stage) with results from a long-latency unit
//   (LU: mul/div, future loads) over valid/ready. Keeps a pending-rd scoreboard for decode
//   hazard checks and forces a pipeline bubble when an LU result starves.
// PARAMETERS
//   XLEN          32  datapath width
//   NREG          32  architectural registers; x0 hard-wired zero
//   STARVE_LIMIT  4   cycles an LU result may wait before stall_pipe is raised (>=1)
// PORTS
//   clk           in   1     core clock
//   rst_n         in   1     asynchronous active-low reset
//   wb_rd         in   5     pipeline writeback rd; 0 = no write
//   wb_data       in   XLEN  pipeline writeback data
//   lu_iss_valid  in   1     decode issues an op to LU this cycle
//   lu_iss_rd     in   5     destination of issued LU op
//   lu_valid      in   1     LU result available
//   lu_rd         in   5     LU result destination
//   lu_data       in   XLEN  LU result data
//   lu_ready      out  1     LU result accepted this cycle
//   q_rs1,q_rs2   in   5     decode source registers to check
//   q_rd          in   5     decode destination to check (WAW)
//   hazard        out  1     any queried register pending in LU
//   pending       out  NREG  scoreboard bitmap (bit 0 always 0)
//   stall_pipe    out  1     pipeline must freeze and present wb_rd=0
//   reg_wr        out  5     register-file write index; 0 = no write
//   reg_wr_data   out  XLEN  register-file write data
// BEHAVIOUR
//   Reset: pending=0, stall_pipe=0, starve counter=0; while rst_n=0 reg_wr=0, lu_ready=0, data=0.
//   Port select (combinational, 0-cycle latency):
//   - wb_rd!=0 and stall_pipe=0 -> reg_wr=wb_rd, data=wb_data, lu_ready=0.
//   - else lu_ready=1; lu_valid & lu_rd!=0 -> reg_wr=lu_rd, data=lu_data; otherwise reg_wr=0.
//   - stall_pipe=1 and wb_rd!=0 is a protocol violation (assert); LU still wins.
//   - LU result with lu_rd=0: handshaken, discarded, scoreboard unchanged.
//   Handshake: LU transfer when lu_valid&lu_ready; LU holds rd/data stable until then.
//   Starvation: counter increments (saturating at STARVE_LIMIT) each cycle lu_valid&!lu_ready;
//   clears on LU transfer or lu_valid=0. stall_pipe is registered: 1 the cycle after counter
//   reaches STARVE_LIMIT, 0 the cycle after the LU transfer.
//   Scoreboard (updates at clock edge, visible next cycle):
//   - set bit lu_iss_rd on lu_iss_valid & lu_iss_rd!=0.
//   - clear bit lu_rd on LU transfer with lu_rd!=0.
//   - same reg set and cleared same cycle -> set wins (newer issue).
//   - hazard = pending[q_rs1]|pending[q_rs2]|pending[q_rd], comb.; retiring reg still
//     reports hazard in its write cycle (no bypass).
//   - issue to an already-pending rd is illegal (assert); decode prevents via hazard on q_rd.
//   Reset mid-operation: scoreboard and counter cleared; in-flight LU results are dropped by the LU's
//   own reset; no write occurs in the cycle rst_n deasserts unless inputs request one.
// STRUCTURE
//   riscv_pkg: XLEN, NREG, REG_IDX_W=5, reg_idx_t typedef, REG_ZERO constant.
//   Sub-module wb_scoreboard: pending bitmap, set/clear logic, 3-port hazard lookup.
//   Top: port-select mux, starvation counter, stall_pipe register.
// TESTING
//   1 wb_rd=5,wb_data=0xA5 with lu_valid=0 -> reg_wr=5, data=0xA5, lu_ready=0, pending unchanged.
//   2 lu_iss rd=7; later lu_valid rd=7 data=0x1234, wb_rd=0 -> write x7=0x1234 same cycle,
//     pending[7] 1 from issue+1 until transfer+1; hazard with q_rs1=7 meanwhile.
//   3 lu_valid held, wb_rd!=0 every cycle, STARVE_LIMIT=4 -> stall_pipe=1 after 4 blocked cycles;
//     bench drives wb_rd=0 -> LU write, stall_pipe=0 next cycle.
//   4 Same cycle: LU retires x3 and lu_iss_rd=3 -> pending[3] stays 1.
//   5 lu_rd=0 with lu_valid -> lu_ready=1, reg_wr=0, pending unchanged; lu_iss_rd=0 sets nothing.
//   6 Assert rst_n=0 with pending=0x0000_0180 and counter=2 -> pending=0, stall_pipe=0,
//     reg_wr=0 immediately (async), counter 0 after release.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, register-index type and helpers for the register-file write arbiter.
package regfile_wr_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xdata_t;
  typedef logic [NREG-1:0]      reg_mask_t;

  localparam reg_idx_t REG_ZERO = '0;

  // One-hot mask for a register index; x0 never produces a bit.
  function automatic reg_mask_t reg_onehot(input reg_idx_t idx, input logic en);
    reg_mask_t m;
    m = '0;
    if (en && (idx != REG_ZERO)) m = NREG'(1) << idx;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of writeback, long-latency-unit, decode-query and register-file write signals.
interface regfile_wr_arbiter_if;
  import regfile_wr_arbiter_pkg::*;

  reg_idx_t  wb_rd;
  xdata_t    wb_data;
  logic      lu_iss_valid;
  reg_idx_t  lu_iss_rd;
  logic      lu_valid;
  reg_idx_t  lu_rd;
  xdata_t    lu_data;
  logic      lu_ready;
  reg_idx_t  q_rs1;
  reg_idx_t  q_rs2;
  reg_idx_t  q_rd;
  logic      hazard;
  reg_mask_t pending;
  logic      stall_pipe;
  reg_idx_t  reg_wr;
  xdata_t    reg_wr_data;

  modport master (
    output wb_rd, wb_data, lu_iss_valid, lu_iss_rd, lu_valid, lu_rd, lu_data,
           q_rs1, q_rs2, q_rd,
    input  lu_ready, hazard, pending, stall_pipe, reg_wr, reg_wr_data
  );

  modport slave (
    input  wb_rd, wb_data, lu_iss_valid, lu_iss_rd, lu_valid, lu_rd, lu_data,
           q_rs1, q_rs2, q_rd,
    output lu_ready, hazard, pending, stall_pipe, reg_wr, reg_wr_data
  );

endinterface

// File: rtl/regfile_wr_arbiter_wb_scoreboard.sv
// Pending-destination scoreboard for LU ops with a three-port hazard lookup (no bypass).
module regfile_wr_arbiter_wb_scoreboard
  import regfile_wr_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_idx_t  set_rd,
  input  logic      clr_en,
  input  reg_idx_t  clr_rd,
  input  reg_idx_t  q_rs1,
  input  reg_idx_t  q_rs2,
  input  reg_idx_t  q_rd,
  output reg_mask_t pending,
  output logic      hazard
);

  reg_mask_t set_mask;
  reg_mask_t clr_mask;
  reg_mask_t pending_d;

  // Set is applied after clear so a same-cycle reissue of a retiring register stays pending.
  always_comb begin
    set_mask  = reg_onehot(set_rd, set_en);
    clr_mask  = reg_onehot(clr_rd, clr_en);
    pending_d = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_d;
  end

  always_comb begin
    hazard = pending[q_rs1] | pending[q_rs2] | pending[q_rd];
  end

  a_no_reissue_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_en && (set_rd != REG_ZERO) && pending[set_rd] &&
      !(clr_en && (clr_rd == set_rd))))
    else $error("LU issue to a register that is already pending");

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port: pipeline writeback has priority, LU results fill gaps,
// and a starving LU result freezes the pipeline until it drains.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wr_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             wb_sel;
  logic             lu_xfer;
  logic             lu_blocked;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             stall_d;

  // Port select; everything is forced quiet while reset is held.
  always_comb begin
    wb_sel          = rst_n && (bus.wb_rd != REG_ZERO) && !bus.stall_pipe;
    bus.lu_ready    = rst_n && !wb_sel;
    bus.reg_wr      = REG_ZERO;
    bus.reg_wr_data = '0;
    if (wb_sel) begin
      bus.reg_wr      = bus.wb_rd;
      bus.reg_wr_data = bus.wb_data;
    end else if (bus.lu_ready && bus.lu_valid && (bus.lu_rd != REG_ZERO)) begin
      bus.reg_wr      = bus.lu_rd;
      bus.reg_wr_data = bus.lu_data;
    end
  end

  // Starvation counter saturates at the limit; stall follows the counter by one edge.
  always_comb begin
    lu_xfer      = bus.lu_valid && bus.lu_ready;
    lu_blocked   = bus.lu_valid && !bus.lu_ready;
    starve_cnt_d = starve_cnt;
    if (!bus.lu_valid || lu_xfer) begin
      starve_cnt_d = '0;
    end else if (lu_blocked && (starve_cnt != CNT_MAX)) begin
      starve_cnt_d = starve_cnt + CNT_W'(1);
    end
    stall_d = (starve_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt     <= '0;
      bus.stall_pipe <= 1'b0;
    end else begin
      starve_cnt     <= starve_cnt_d;
      bus.stall_pipe <= stall_d;
    end
  end

  regfile_wr_arbiter_wb_scoreboard u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (bus.lu_iss_valid),
    .set_rd  (bus.lu_iss_rd),
    .clr_en  (lu_xfer),
    .clr_rd  (bus.lu_rd),
    .q_rs1   (bus.q_rs1),
    .q_rs2   (bus.q_rs2),
    .q_rd    (bus.q_rd),
    .pending (bus.pending),
    .hazard  (bus.hazard)
  );

  // A frozen pipeline must not present a writeback.
  a_no_wb_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.stall_pipe && (bus.wb_rd != REG_ZERO)))
    else $error("pipeline writeback presented while stall_pipe is high");

endmodule
